// File: rtl/rv_plic_gateway_ctrl.sv
// PLIC interrupt gateway: turns raw level/edge sources into the pending vector
// for the target arbiter and enforces one outstanding request per source via
// the claim/complete handshake. Edge bursts are queued in a saturating counter.

// Per-source gateway slice: FSM, registered source copy, queued-edge counter.
module rv_plic_gateway_src #(
  parameter int EDGE_CNT_W = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o,
  output logic ovf_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    CLAIMED = 2'd2
  } state_e;

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);

  state_e                  state_q, state_d;
  logic [EDGE_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    src_q;
  logic                    ovf_q, ovf_d;
  logic                    evt;
  logic                    busy;

  // Edge mode fires on a rising edge; level mode fires whenever the line is high.
  // src_q resets low, so a line already high at reset release counts as an edge.
  assign evt  = le_i ? (src_i & ~src_q) : src_i;
  assign busy = (state_q == PEND) || (state_q == CLAIMED);

  // State, counter, source copy and overflow pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_i;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: handshake transitions plus edge queuing on the side.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // A fresh event takes priority over the queue so nothing is lost.
        if (evt) begin
          state_d = PEND;
        end else if (le_i && (cnt_q != '0)) begin
          state_d = PEND;
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      PEND: begin
        // complete in PEND is ignored; a level request stays latched until claimed.
        if (claim_i) state_d = CLAIMED;
      end
      CLAIMED: begin
        // claim in CLAIMED is ignored.
        if (complete_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Edges arriving while a request is outstanding are queued, including the
    // cycle a complete moves us back to IDLE; a full queue drops and flags it.
    if (le_i && evt && busy) begin
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
      else                  cnt_d = cnt_q + CNT_ONE;
    end

    // Level-mode sources never carry queued edges.
    if (!le_i) cnt_d = '0;
  end

  // Pending is a pure decode of registered state.
  assign ip_o  = (state_q == PEND);
  assign ovf_o = ovf_q;

endmodule

module rv_plic_gateway_ctrl #(
  parameter int N_SOURCE   = 32,
  parameter int EDGE_CNT_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [N_SOURCE-1:0] src_i,
  input  logic [N_SOURCE-1:0] le_i,
  input  logic [N_SOURCE-1:0] claim_i,
  input  logic [N_SOURCE-1:0] complete_i,
  output logic [N_SOURCE-1:0] ip_o,
  output logic [N_SOURCE-1:0] ovf_o
);

  // Sources are fully independent: one slice per source, no cross-source logic.
  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    rv_plic_gateway_src #(
      .EDGE_CNT_W (EDGE_CNT_W)
    ) u_src (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .src_i      (src_i[i]),
      .le_i       (le_i[i]),
      .claim_i    (claim_i[i]),
      .complete_i (complete_i[i]),
      .ip_o       (ip_o[i]),
      .ovf_o      (ovf_o[i])
    );
  end

endmodule

// File: tb/tb_rv_plic_gateway_ctrl.sv
// Directed + random bench for rv_plic_gateway_ctrl. Every cycle the reference
// model's expected ip/ovf is pushed to a scoreboard and compared after the edge;
// directed steps add constant checks from the test plan.
module tb_rv_plic_gateway_ctrl;
  localparam int N   = 32;
  localparam int W   = 2;
  localparam int MAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src, le, claim, complete;
  logic [N-1:0] ip, ovf;

  always #5 clk = ~clk;

  rv_plic_gateway_ctrl #(.N_SOURCE(N), .EDGE_CNT_W(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .src_i      (src),
    .le_i       (le),
    .claim_i    (claim),
    .complete_i (complete),
    .ip_o       (ip),
    .ovf_o      (ovf)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: 0 = idle, 1 = pending, 2 = claimed.
  int m_st [N];
  int m_cnt[N];
  bit m_sq [N];
  bit m_ovf[N];

  typedef struct packed {
    logic [N-1:0] ip;
    logic [N-1:0] ovf;
  } exp_t;
  exp_t sbq[$];

  function automatic void model_step();
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_st[i] = 0; m_cnt[i] = 0; m_sq[i] = 0; m_ovf[i] = 0;
      end else begin
        bit e;
        int nst, ncnt;
        e = le[i] ? (src[i] && !m_sq[i]) : src[i];
        nst = m_st[i]; ncnt = m_cnt[i]; m_ovf[i] = 0;
        if (m_st[i] == 0) begin
          if (e) nst = 1;
          else if (le[i] && m_cnt[i] > 0) begin nst = 1; ncnt = m_cnt[i] - 1; end
        end else begin
          if (m_st[i] == 1 && claim[i])    nst = 2;
          if (m_st[i] == 2 && complete[i]) nst = 0;
          if (le[i] && e) begin
            if (m_cnt[i] >= MAX) m_ovf[i] = 1;
            else ncnt = m_cnt[i] + 1;
          end
        end
        if (!le[i]) ncnt = 0;
        m_st[i] = nst; m_cnt[i] = ncnt; m_sq[i] = src[i];
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: model, push expectation, clock, pop and compare.
  task automatic tick();
    exp_t e;
    model_step();
    for (int i = 0; i < N; i++) begin
      e.ip[i]  = (m_st[i] == 1);
      e.ovf[i] = m_ovf[i];
    end
    sbq.push_back(e);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("sb_ip", ip, e.ip);
      chk("sb_ovf", ovf, e.ovf);
    end
  endtask

  int n_ip;

  initial begin
    rst = 1'b1; src = '0; le = '0; claim = '0; complete = '0;

    // Reset
    tick();
    chk("rst_ip", ip, '0);
    chk("rst_ovf", ovf, '0);
    rst = 1'b0;
    tick();

    // Level mode on source 3
    src[3] = 1'b1; tick();
    chk("lvl_set", 32'(ip[3]), 32'd1);
    src[3] = 1'b0; tick(); tick();
    chk("lvl_latched", 32'(ip[3]), 32'd1);
    claim[3] = 1'b1; tick(); claim[3] = 1'b0;
    chk("lvl_claim", 32'(ip[3]), 32'd0);
    complete[3] = 1'b1; tick(); complete[3] = 1'b0; tick();
    chk("lvl_complete_low", 32'(ip[3]), 32'd0);

    // Handshake misuse on source 5 (level)
    claim[5] = 1'b1; complete[5] = 1'b1; tick();
    claim[5] = 1'b0; complete[5] = 1'b0; tick();
    chk("misuse_idle", 32'(ip[5]), 32'd0);
    src[5] = 1'b1; tick(); src[5] = 1'b0;
    complete[5] = 1'b1; tick(); complete[5] = 1'b0;
    chk("misuse_pend", 32'(ip[5]), 32'd1);
    claim[5] = 1'b1; tick(); claim[5] = 1'b0;
    complete[5] = 1'b1; tick(); complete[5] = 1'b0; tick();
    chk("misuse_done", 32'(ip[5]), 32'd0);

    // Edge burst on source 0: first edge pends, four more queue/overflow
    le[0] = 1'b1; tick();
    src[0] = 1'b1; tick(); src[0] = 1'b0; tick();
    chk("burst_pend", 32'(ip[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      src[0] = 1'b1; tick();
      chk($sformatf("burst_ovf%0d", k), 32'(ovf[0]), (k == 3) ? 32'd1 : 32'd0);
      src[0] = 1'b0; tick();
      chk("burst_ovf_clr", 32'(ovf[0]), 32'd0);
    end
    n_ip = ip[0] ? 1 : 0;
    for (int k = 0; k < 4; k++) begin
      claim[0] = 1'b1; tick(); claim[0] = 1'b0;
      complete[0] = 1'b1; tick(); complete[0] = 1'b0;
      tick();
      if (ip[0]) n_ip++;
    end
    chk("burst_count", 32'(n_ip), 32'd4);
    tick(); tick();
    chk("burst_drained", 32'(ip[0]), 32'd0);

    // Complete and rising edge in the same cycle on source 0
    src[0] = 1'b1; tick();
    claim[0] = 1'b1; tick(); claim[0] = 1'b0;
    src[0] = 1'b0; tick();
    src[0] = 1'b1; complete[0] = 1'b1; tick(); complete[0] = 1'b0;
    chk("simul_k1", 32'(ip[0]), 32'd0);
    tick();
    chk("simul_k2", 32'(ip[0]), 32'd1);
    claim[0] = 1'b1; tick(); claim[0] = 1'b0;
    complete[0] = 1'b1; tick(); complete[0] = 1'b0; tick();
    chk("simul_cnt0", 32'(ip[0]), 32'd0);
    src[0] = 1'b0; tick();

    // Reset mid-operation: 1 pending, 2 claimed, 4 with two queued edges
    le[1] = 1'b1; le[2] = 1'b1; le[4] = 1'b1; tick();
    src[1] = 1'b1; src[2] = 1'b1; src[4] = 1'b1; tick();
    src[1] = 1'b0; src[2] = 1'b0; src[4] = 1'b0; claim[2] = 1'b1; tick(); claim[2] = 1'b0;
    src[4] = 1'b1; tick(); src[4] = 1'b0; tick(); src[4] = 1'b1; tick();
    chk("pre_rst_ip", ip & 32'h16, 32'h12);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_ip", ip, '0);
    chk("midrst_ovf", ovf, '0);
    tick();
    chk("post_rst_retrig", ip & 32'h16, 32'h10);
    src = '0; rst = 1'b1; tick(); rst = 1'b0; le = '0;

    // Random mixed-mode traffic; scoreboard checks every source each cycle
    le = $urandom();
    for (int c = 0; c < 400; c++) begin
      src      = $urandom();
      claim    = $urandom() & $urandom();
      complete = $urandom() & $urandom();
      if (c % 97 == 50) le = le ^ ($urandom() & $urandom() & $urandom());
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv_plic_gateway_ctrl.md
Name: rv_plic_gateway_ctrl

Overview:
- Per-source interrupt gateway sitting directly upstream of the PLIC target priority/threshold arbiter.
- Converts raw level or edge interrupt sources into the pending vector `ip_o`, which the arbiter consumes.
- Enforces the claim/complete handshake: at most one request per source is outstanding at any time.
- In edge mode, queues additional edges in a saturating counter so that bursts are not lost.

Parameters:
- N_SOURCE, 32, number of interrupt sources.
- EDGE_CNT_W, 2, width of the per-source queued-edge counter; the maximum queued edge count is 2^EDGE_CNT_W-1.

Ports:
- clk_i  input  1  clock; all logic is rising-edge triggered.
- rst_i  input  1  synchronous reset, active high.
- src_i  input  N_SOURCE  raw interrupt sources, already synchronous to clk_i.
- le_i  input  N_SOURCE  mode per source: 1 = edge-triggered, 0 = level-triggered.
- claim_i  input  N_SOURCE  one-cycle pulse; the target has claimed source i.
- complete_i  input  N_SOURCE  one-cycle pulse; the handler has completed source i.
- ip_o  output  N_SOURCE  pending vector to the target arbiter.
- ovf_o  output  N_SOURCE  one-cycle pulse; an edge was dropped because the counter was saturated.

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high (`rst_i` sampled on the rising edge of `clk_i`).
  - While `rst_i` = 1 at a clock edge, every source goes to IDLE, `cnt` = 0, `src_q` = 0, `ip_o` = 0, `ovf_o` = 0.
  - Reset mid-operation discards in-flight claims and queued edges. No complete is expected afterwards.
- Per-source state: FSM {IDLE, PEND, CLAIMED}, `src_q` (1-bit registered copy of `src_i`), `cnt` (EDGE_CNT_W bits).
- Event definition:
  - Edge mode: `evt = src_i & ~src_q`.
  - Level mode: `evt = src_i`.
  - Because `src_q` resets to 0, a source that is high when reset releases counts as an edge.
- `ip_o[i]` = 1 exactly when source i is in PEND. It is a pure decode of registered state, with no combinational path from inputs.
- Latency: `evt` true in cycle k, with the source in IDLE → PEND and `ip_o` = 1 in cycle k+1.
- IDLE transitions:
  - `evt` → PEND; the event is consumed and `cnt` is unchanged.
  - Otherwise, edge mode with `cnt` > 0 → PEND and `cnt` decrements.
  - Otherwise stay in IDLE.
- PEND transitions:
  - `claim_i` → CLAIMED.
  - `complete_i` in PEND is ignored.
  - Level mode: `src_i` deasserting does not clear PEND; the request stays latched until claimed.
- CLAIMED transitions:
  - `complete_i` → IDLE.
  - `claim_i` in CLAIMED is ignored.
  - The next request can assert `ip_o` no earlier than one cycle after entering IDLE. Complete in cycle k → IDLE in k+1 → PEND in k+2 at the earliest.
- Edge queuing:
  - In edge mode, `evt` while in PEND or CLAIMED increments `cnt`, saturating at 2^EDGE_CNT_W-1.
  - If `cnt` is already saturated, the edge is dropped and `ovf_o[i]` pulses for 1 cycle (registered, next cycle).
  - Level-mode events in PEND/CLAIMED are not counted.
- Simultaneous events:
  - CLAIMED with `complete_i` and edge `evt` in the same cycle → IDLE, and `cnt` increments (saturating).
  - IDLE with `evt` while `cnt` > 0 → PEND, `cnt` unchanged (no decrement, no loss).
  - `claim_i` and `complete_i` together: only the one legal for the current state acts.
- Mode change:
  - When `le_i[i]` = 0, `cnt[i]` is forced to 0 on the next edge. The FSM state is preserved.
  - `le_i` is sampled every cycle.
- Independence: sources are fully independent; there is no cross-source arbitration in this block.

Test Plan:
- Level mode:
  - Stimulus: `src_i[3]`=1 at cycle 10.
  - Required: `ip_o[3]`=1 from cycle 11.
  - Drop `src_i[3]` at 12 → `ip_o[3]` stays 1.
  - `claim_i[3]` at 15 → `ip_o[3]`=0 from 16.
  - `complete_i[3]` at 20 with `src_i` low → `ip_o[3]` stays 0.
- Edge burst:
  - Stimulus: `le_i[0]`=1, then 4 rising edges on `src_i[0]` while PEND/CLAIMED, with EDGE_CNT_W=2.
  - Required: `cnt` saturates at 3; the 4th queued edge produces an `ovf_o[0]` pulse.
  - After 4 claim/complete cycles, `ip_o[0]` has asserted exactly 4 times, then stays 0.
- Handshake misuse:
  - Stimulus: `complete_i[5]` while IDLE, and `claim_i[5]` while IDLE.
  - Required: no state change and `ip_o[5]`=0.
  - Stimulus: `complete_i[5]` while PEND.
  - Required: `ip_o[5]` stays 1.
- Simultaneous complete and edge:
  - Stimulus: edge source in CLAIMED with `cnt`=0; `complete_i` and a rising `src_i` in the same cycle k.
  - Required: `ip_o`=0 in k+1, then `ip_o`=1 in k+2 with `cnt` back to 0.
- Reset mid-operation:
  - Stimulus: sources 1 (PEND), 2 (CLAIMED), 4 (`cnt`=2) active; assert `rst_i` for 1 cycle.
  - Required: `ip_o`=0 and `ovf_o`=0 next cycle; `src_i` held high in edge mode re-triggers PEND one cycle after reset release.
- Independence:
  - Stimulus: 32 sources toggled randomly in mixed modes.
  - Required: each `ip_o[i]` matches a per-source reference model, with no cross-talk.
